// File: rtl/scan_test_controller.sv
// Tester-side scan initiator: shifts a pattern into an SDFF chain, pulses one
// functional capture, unloads the response and compares it under a mask.
module scan_test_controller #(
  parameter int CHAIN_LEN = 4
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PATTERN,
  input  logic [CHAIN_LEN-1:0] EXPECT,
  input  logic [CHAIN_LEN-1:0] MASK,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESPONSE,
  output logic                 PASS
);

  localparam int CW = $clog2(CHAIN_LEN + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CAPTURE,
    UNLOAD,
    DONE_ST
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-1:0] mask_q, mask_d;
  logic [CHAIN_LEN-1:0] resp_sh_q, resp_sh_d;
  logic [CHAIN_LEN-1:0] resp_q, resp_d;
  logic [CHAIN_LEN-1:0] resp_next;
  logic                 se_q, se_d;
  logic                 si_q, si_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 last_bit;

  assign SE       = se_q;
  assign SI       = si_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign RESPONSE = resp_q;
  assign PASS     = pass_q;

  // Every output is a flop; the comb block below computes their next values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pat_q     <= '0;
      exp_q     <= '0;
      mask_q    <= '0;
      resp_sh_q <= '0;
      resp_q    <= '0;
      se_q      <= 1'b0;
      si_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      exp_q     <= exp_d;
      mask_q    <= mask_d;
      resp_sh_q <= resp_sh_d;
      resp_q    <= resp_d;
      se_q      <= se_d;
      si_q      <= si_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  // The pattern is held pre-shifted so its MSB is always the next bit to drive;
  // SO samples enter at bit 0 so the first one (FFn) ends up in the MSB.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    exp_d     = exp_q;
    mask_d    = mask_q;
    resp_sh_d = resp_sh_q;
    resp_d    = resp_q;
    se_d      = se_q;
    si_d      = si_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;

    last_bit     = (cnt_q == CW'(CHAIN_LEN - 1));
    resp_next    = resp_sh_q << 1;
    resp_next[0] = SO;

    case (state_q)
      IDLE: begin
        se_d   = 1'b0;
        si_d   = 1'b0;
        busy_d = 1'b0;
        if (START) begin
          state_d = LOAD;
          cnt_d   = '0;
          pat_d   = PATTERN << 1;
          exp_d   = EXPECT;
          mask_d  = MASK;
          se_d    = 1'b1;
          si_d    = PATTERN[CHAIN_LEN-1];
          busy_d  = 1'b1;
        end
      end

      LOAD: begin
        if (last_bit) begin
          state_d = CAPTURE;
          cnt_d   = '0;
          se_d    = 1'b0;
          si_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          si_d  = pat_q[CHAIN_LEN-1];
          pat_d = pat_q << 1;
        end
      end

      CAPTURE: begin
        state_d   = UNLOAD;
        cnt_d     = '0;
        resp_sh_d = '0;
        se_d      = 1'b1;
        si_d      = 1'b0;
      end

      UNLOAD: begin
        resp_sh_d = resp_next;
        if (last_bit) begin
          state_d = DONE_ST;
          cnt_d   = '0;
          se_d    = 1'b0;
          done_d  = 1'b1;
          resp_d  = resp_next;
          pass_d  = (((resp_next ^ exp_q) & mask_q) == '0);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE_ST: begin
        state_d = IDLE;
        se_d    = 1'b0;
        si_d    = 1'b0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        se_d    = 1'b0;
        si_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_scan_test_controller.sv
// Bench for scan_test_controller driving a behavioural 4-flop SDFF chain whose
// functional DI inputs are set by the bench.
module tb_scan_test_controller;

  logic       CLK;
  logic       RSTn;
  logic       START;
  logic [3:0] PATTERN;
  logic [3:0] EXPECT;
  logic [3:0] MASK;
  logic       SO;
  logic       SE;
  logic       SI;
  logic       BUSY;
  logic       DONE;
  logic [3:0] RESPONSE;
  logic       PASS;

  logic [3:0] di;
  logic [3:0] chain = 4'b0000;

  int tests_run = 0;
  int tests_failed = 0;

  scan_test_controller #(.CHAIN_LEN(4)) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .START    (START),
    .PATTERN  (PATTERN),
    .EXPECT   (EXPECT),
    .MASK     (MASK),
    .SO       (SO),
    .SE       (SE),
    .SI       (SI),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .RESPONSE (RESPONSE),
    .PASS     (PASS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // chain[0] is FF1 (fed by SI), chain[3] is FFn (drives SO).
  always @(posedge CLK) begin
    if (SE) chain <= {chain[2:0], SI};
    else    chain <= di;
  end
  assign SO = chain[3];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One full test started with a one-cycle START pulse; inputs are scrambled
  // after the START edge to prove they were latched.
  task automatic apply_stimulus(input string tag, input logic [3:0] pat, input logic [3:0] exp,
                                input logic [3:0] msk, input logic [3:0] dval,
                                input logic [3:0] exp_si, input logic [3:0] exp_resp,
                                input logic exp_pass);
    logic [3:0] si_seen;
    logic [3:0] se_seen;
    logic [3:0] unl_se;
    logic [3:0] unl_done;
    PATTERN = pat;
    EXPECT  = exp;
    MASK    = msk;
    di      = dval;
    START   = 1'b1;
    step();
    START   = 1'b0;
    PATTERN = ~pat;
    EXPECT  = ~exp;
    MASK    = ~msk;
    for (int j = 0; j < 4; j++) begin
      si_seen[3-j] = SI;
      se_seen[3-j] = SE;
      if (j < 3) step();
    end
    check_output({tag, " si_seq"}, 32'(si_seen), 32'(exp_si));
    check_output({tag, " se_load"}, 32'(se_seen), 32'hF);
    step();
    check_output({tag, " se_capture"}, 32'(SE), 32'h0);
    check_output({tag, " loaded_chain"}, 32'(chain), 32'(pat));
    for (int j = 0; j < 4; j++) begin
      step();
      unl_se[3-j]   = SE;
      unl_done[3-j] = DONE;
    end
    check_output({tag, " se_unload"}, 32'(unl_se), 32'hF);
    check_output({tag, " done_early"}, 32'(unl_done), 32'h0);
    step();
    check_output({tag, " done_c10"}, 32'(DONE), 32'h1);
    check_output({tag, " busy_c10"}, 32'(BUSY), 32'h1);
    check_output({tag, " response"}, 32'(RESPONSE), 32'(exp_resp));
    check_output({tag, " pass"}, 32'(PASS), 32'(exp_pass));
    step();
    check_output({tag, " done_c11"}, 32'(DONE), 32'h0);
    check_output({tag, " busy_c11"}, 32'(BUSY), 32'h0);
    check_output({tag, " response_hold"}, 32'(RESPONSE), 32'(exp_resp));
  endtask

  initial begin
    logic [21:0] done_map;
    logic [21:0] busy_low_map;
    int done_cnt;
    RSTn    = 1'b0;
    START   = 1'b0;
    PATTERN = 4'h0;
    EXPECT  = 4'h0;
    MASK    = 4'h0;
    di      = 4'h0;
    #2;
    check_output("reset busy", 32'(BUSY), 32'h0);
    check_output("reset se_si", 32'({SE, SI}), 32'h0);
    check_output("reset done_pass", 32'({DONE, PASS}), 32'h0);
    check_output("reset response", 32'(RESPONSE), 32'h0);
    step();
    RSTn = 1'b1;
    step();
    step();

    apply_stimulus("t2", 4'b1010, 4'b0110, 4'hF, 4'b0110, 4'b1010, 4'b0110, 1'b1);
    apply_stimulus("t3a", 4'b1010, 4'b0111, 4'hF, 4'b0110, 4'b1010, 4'b0110, 1'b0);
    apply_stimulus("t3b", 4'b1010, 4'b0111, 4'b1110, 4'b0110, 4'b1010, 4'b0110, 1'b1);

    // Async reset in the middle of UNLOAD (cycle 7).
    PATTERN = 4'b1100;
    EXPECT  = 4'b0000;
    MASK    = 4'hF;
    di      = 4'b1001;
    START   = 1'b1;
    step();
    START = 1'b0;
    for (int c = 1; c < 7; c++) step();
    check_output("t1 pre_reset se", 32'(SE), 32'h1);
    RSTn = 1'b0;
    #1;
    check_output("t1 reset se_si", 32'({SE, SI}), 32'h0);
    check_output("t1 reset busy_done", 32'({BUSY, DONE}), 32'h0);
    check_output("t1 reset response", 32'(RESPONSE), 32'h0);
    check_output("t1 reset pass", 32'(PASS), 32'h0);
    step();
    RSTn = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (BUSY || SE || DONE) done_cnt++;
    end
    check_output("t1 idle_after_reset", 32'(done_cnt), 32'h0);

    // START pulsed again in cycle 3 of a running test.
    PATTERN = 4'b0011;
    EXPECT  = 4'b1000;
    MASK    = 4'hF;
    di      = 4'b1000;
    START   = 1'b1;
    step();
    START = 1'b0;
    done_cnt = 0;
    for (int c = 1; c < 26; c++) begin
      START = (c == 3);
      if (DONE) done_cnt++;
      if (c == 10) check_output("t4 done_c10", 32'(DONE), 32'h1);
      step();
    end
    START = 1'b0;
    check_output("t4 done_count", 32'(done_cnt), 32'h1);
    check_output("t4 pass", 32'(PASS), 32'h1);
    check_output("t4 busy_end", 32'(BUSY), 32'h0);

    apply_stimulus("t6", 4'b0000, 4'b1111, 4'hF, 4'b1111, 4'b0000, 4'b1111, 1'b1);

    // START held high: back-to-back tests with a one-cycle IDLE gap.
    PATTERN = 4'b0101;
    EXPECT  = 4'b0101;
    MASK    = 4'hF;
    di      = 4'b0101;
    START   = 1'b1;
    done_map     = '0;
    busy_low_map = '0;
    for (int c = 0; c < 30; c++) begin
      if (c < 22) begin
        done_map[c]     = DONE;
        busy_low_map[c] = ~BUSY;
      end
      step();
    end
    START = 1'b0;
    check_output("t5 done_cycles", 32'(done_map), 32'h0020_0400);
    check_output("t5 busy_low_cycles", 32'(busy_low_map), 32'h0000_0801);
    done_cnt = 0;
    while (BUSY && done_cnt < 40) begin
      step();
      done_cnt++;
    end
    check_output("t5 drains_to_idle", 32'(BUSY), 32'h0);
    check_output("t5 response", 32'(RESPONSE), 32'h5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
